// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: sequences boot hold-off, load-use stalls,
// branch redirect squashes and halt, and counts stall/flush events for debug.
module fetch_sequencer #(
    parameter int BOOT_CYCLES = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_use_hazard,
    input  logic                 branch_taken,
    input  logic                 branch_reg,
    input  logic                 halt_detect,
    input  logic                 resume,
    output logic                 PCWrite,
    output logic                 Branchreg,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic [2:0]           state_out,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic br_reg;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
    } ctl_t;

    localparam logic [3:0] BOOT_INIT    = 4'(BOOT_CYCLES - 1);
    localparam logic [1:0] FLUSH_RELOAD = 2'((FLUSH_DEPTH > 1) ? (FLUSH_DEPTH - 2) : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [3:0]           boot_q, boot_d;
    logic [1:0]           fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0] stall_count_q, flush_count_q;
    logic                 stall_inc, flush_inc;
    ctl_t                 ctl;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_BOOT;
            boot_q        <= BOOT_INIT;
            fcnt_q        <= 2'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            fcnt_q  <= fcnt_d;
            if (stall_inc && (stall_count_q != '1))
                stall_count_q <= stall_count_q + CNT_ONE;
            if (flush_inc && (flush_count_q != '1))
                flush_count_q <= flush_count_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        boot_d    = boot_q;
        fcnt_d    = fcnt_q;
        ctl       = '0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            S_BOOT: begin
                ctl.ifid_flush = 1'b1;
                if (boot_q == 4'd0)
                    state_d = S_RUN;
                else
                    boot_d = boot_q - 4'd1;
            end
            // STALL behaves like an idle RUN cycle, but a redirect still wins.
            S_RUN, S_STALL: begin
                if (branch_taken) begin
                    ctl.pc_write   = 1'b1;
                    ctl.br_reg     = branch_reg;
                    ctl.ifid_write = 1'b1;
                    ctl.ifid_flush = 1'b1;
                    flush_inc      = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FLUSH_RELOAD;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if ((state_q == S_RUN) && load_use_hazard) begin
                    ctl.idex_bubble = 1'b1;
                    stall_inc       = 1'b1;
                    state_d         = S_STALL;
                end else if ((state_q == S_RUN) && halt_detect) begin
                    ctl.idex_bubble = 1'b1;
                    state_d         = S_HALT;
                end else begin
                    ctl.pc_write   = 1'b1;
                    ctl.ifid_write = 1'b1;
                    state_d        = S_RUN;
                end
            end
            // Hazard/halt here belong to squashed instructions and are dropped.
            S_FLUSH: begin
                ctl.pc_write    = 1'b1;
                ctl.ifid_write  = 1'b1;
                ctl.ifid_flush  = 1'b1;
                ctl.idex_bubble = 1'b1;
                flush_inc       = 1'b1;
                if (branch_taken) begin
                    ctl.br_reg = branch_reg;
                    fcnt_d     = FLUSH_RELOAD;
                end else if (fcnt_q == 2'd0) begin
                    state_d = S_RUN;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
            S_HALT: begin
                ctl.idex_bubble = 1'b1;
                if (resume)
                    state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // BOOT drives a flush, so outputs must be forced low while reset is held.
    assign PCWrite      = ctl.pc_write    & ~reset;
    assign Branchreg    = ctl.br_reg      & ~reset;
    assign if_id_write  = ctl.ifid_write  & ~reset;
    assign if_id_flush  = ctl.ifid_flush  & ~reset;
    assign id_ex_bubble = ctl.idex_bubble & ~reset;
    assign state_out    = state_q;
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected per-cycle outputs are queued
// as stimulus is planned and popped for comparison mid-cycle.
module tb_fetch_sequencer;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset, load_use_hazard, branch_taken, branch_reg, halt_detect, resume;
    logic PCWrite, Branchreg, if_id_write, if_id_flush, id_ex_bubble;
    logic [2:0]    state_out;
    logic [CW-1:0] stall_count, flush_count;

    typedef struct {
        logic [7:0]  o;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int msc = 0;
    int mfc = 0;

    fetch_sequencer #(.BOOT_CYCLES(4), .FLUSH_DEPTH(2), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .load_use_hazard(load_use_hazard),
        .branch_taken(branch_taken), .branch_reg(branch_reg),
        .halt_detect(halt_detect), .resume(resume), .PCWrite(PCWrite),
        .Branchreg(Branchreg), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .state_out(state_out),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] E(input logic pc, br, w, fl, bub, input logic [2:0] st);
        return {pc, br, w, fl, bub, st};
    endfunction

    function automatic logic [7:0] obs();
        return {PCWrite, Branchreg, if_id_write, if_id_flush, id_ex_bubble, state_out};
    endfunction

    function automatic logic [15:0] sat(input int v);
        return (v > 15) ? 16'd15 : 16'(v);
    endfunction

    // stimulus bits: {branch_taken, branch_reg, load_use_hazard, halt_detect, resume}
    task automatic drive(input logic [4:0] s);
        {branch_taken, branch_reg, load_use_hazard, halt_detect, resume} = s;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(5'b00000);
        for (int i = 0; i < 3; i++) sb.push_back('{8'h00, 16'd0, 16'd0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL reset c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_boot();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back('{E(0,0,0,1,0,0), sat(msc), sat(mfc)});
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL boot c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        logic [4:0] stim [3] = '{5'b00100, 5'b00000, 5'b00000};
        sb.push_back('{E(0,0,0,0,1,1), sat(msc), sat(mfc)}); msc++;
        sb.push_back('{E(1,0,1,0,0,2), sat(msc), sat(mfc)});
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL load_use c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] stim [5] = '{5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
        sb.push_back('{E(0,0,0,0,1,1), sat(msc), sat(mfc)}); msc++;
        sb.push_back('{E(1,0,1,0,0,2), sat(msc), sat(mfc)});
        sb.push_back('{E(0,0,0,0,1,1), sat(msc), sat(mfc)}); msc++;
        sb.push_back('{E(1,0,1,0,0,2), sat(msc), sat(mfc)});
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 5; i++) begin
            drive(stim[i]);
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL back_to_back c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_reg_branch();
        logic [4:0] stim [3] = '{5'b11000, 5'b00000, 5'b00000};
        sb.push_back('{E(1,1,1,1,0,1), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,1,1,3), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL reg_branch c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_collision();
        logic [4:0] stim [4] = '{5'b10110, 5'b00110, 5'b00000, 5'b00000};
        sb.push_back('{E(1,0,1,1,0,1), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,1,1,3), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL collision c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_stall_branch();
        logic [4:0] stim [4] = '{5'b00100, 5'b11000, 5'b00000, 5'b00000};
        sb.push_back('{E(0,0,0,0,1,1), sat(msc), sat(mfc)}); msc++;
        sb.push_back('{E(1,1,1,1,0,2), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,1,1,3), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL stall_branch c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_flush_restart();
        logic [4:0] stim [4] = '{5'b10000, 5'b11000, 5'b00000, 5'b00000};
        sb.push_back('{E(1,0,1,1,0,1), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,1,1,1,1,3), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,1,1,3), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL flush_restart c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        logic [4:0] stim;
        sb.push_back('{E(0,0,0,0,1,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 11; i++) sb.push_back('{E(0,0,0,0,1,4), sat(msc), sat(mfc)});
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 13; i++) begin
            if (i == 0)       stim = 5'b00010;
            else if (i == 11) stim = 5'b00001;
            else if (i == 12) stim = 5'b00000;
            else              stim = (i % 2 == 1) ? 5'b11000 : 5'b00000;
            drive(stim);
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL halt c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        sb.push_back('{E(1,0,1,1,0,1), sat(msc), sat(mfc)}); mfc++;
        sb.push_back('{E(1,0,1,1,1,3), sat(msc), sat(mfc)});
        msc = 0; mfc = 0;
        sb.push_back('{8'h00, 16'd0, 16'd0});
        sb.push_back('{8'h00, 16'd0, 16'd0});
        sb.push_back('{E(0,0,0,1,0,0), 16'd0, 16'd0});
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(5'b10000);
                1: drive(5'b00000);
                2: reset = 1'b1;
                4: reset = 1'b0;
                default: ;
            endcase
            if (i == 1 || i == 2) #1;
            else @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL async_reset c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            if (i != 1 && i != 2) tick();
        end
    endtask

    task automatic test_saturate();
        // first boot cycle was consumed by test_async_reset
        for (int i = 0; i < 3; i++) sb.push_back('{E(0,0,0,1,0,0), 16'd0, 16'd0});
        for (int i = 0; i < 44; i++) begin
            if (i % 2 == 0) begin
                sb.push_back('{E(0,0,0,0,1,1), sat(msc), sat(mfc)}); msc++;
            end else begin
                sb.push_back('{E(1,0,1,0,0,2), sat(msc), sat(mfc)});
            end
        end
        sb.push_back('{E(1,0,1,0,0,1), sat(msc), sat(mfc)});
        for (int i = 0; i < 48; i++) begin
            drive((i >= 3 && i < 47) ? 5'b00100 : 5'b00000);
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.o || 16'(stall_count) !== e.sc || 16'(flush_count) !== e.fc) begin
                errors++;
                $display("FAIL saturate c%0d got out=%b sc=%0d fc=%0d want out=%b sc=%0d fc=%0d",
                         i, obs(), stall_count, flush_count, e.o, e.sc, e.fc);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_load_use();
        test_back_to_back();
        test_reg_branch();
        test_collision();
        test_stall_branch();
        test_flush_restart();
        test_halt();
        test_async_reset();
        test_saturate();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM for the instruction-fetch stage of the pipelined ARMv8 core.
- Drives the PC write enable and the register-branch PC-source select into instruction fetch.
- Drives the IF/ID write-enable and flush, plus the ID/EX bubble insert.
- Arbitrates between boot hold-off, load-use stalls, branch redirects and halt, and keeps stall/flush event counters for debug.

Parameters:
- BOOT_CYCLES, 4, cycles PC is held after reset release before fetch starts (1..15).
- FLUSH_DEPTH, 2, younger fetched instructions squashed per taken branch (1..3).
- CNT_WIDTH, 16, width of stall_count and flush_count.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately.
- load_use_hazard  in  1  from hazard detection; ID instruction depends on a load in EX.
- branch_taken  in  1  branch resolved taken this cycle; target is valid on the datapath.
- branch_reg  in  1  the resolving branch is register-indirect (BR).
- halt_detect  in  1  halt opcode decoded in ID.
- resume  in  1  debug pulse that leaves HALT.
- PCWrite  out  1  1 = PC loads next-PC mux output; 0 = PC holds.
- Branchreg  out  1  1 = next PC from read_data_1; 0 = from add_pc.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID register clears to NOP next edge.
- id_ex_bubble  out  1  ID/EX control fields zeroed next edge.
- state_out  out  3  current state encoding.
- stall_count  out  CNT_WIDTH  cycles spent stalling.
- flush_count  out  CNT_WIDTH  squash cycles issued.

Behaviour:
- States and encodings: BOOT=0, RUN=1, STALL=2, FLUSH=3, HALT=4. Encodings 5..7 are illegal and go to RUN next edge.
- Reset behaviour:
  - State = BOOT; boot counter = BOOT_CYCLES-1; flush counter = 0; stall_count = 0; flush_count = 0.
  - All outputs are 0 while reset is high, except state_out = 0.
  - Reset mid-operation aborts any stall, flush or halt immediately.
- Outputs are a combinational decode of state plus the current inputs; there are no registered outputs except the counters.
- BOOT:
  - PCWrite=0, if_id_write=0, if_id_flush=1.
  - Decrement the boot counter each cycle; at 0, go to RUN.
  - All other inputs are ignored.
- RUN, evaluated in this priority order:
  1. branch_taken=1: PCWrite=1, Branchreg=branch_reg, if_id_write=1, if_id_flush=1, id_ex_bubble=0; flush_count+1. If FLUSH_DEPTH>1, go to FLUSH with flush counter = FLUSH_DEPTH-2; else stay in RUN.
  2. load_use_hazard=1: PCWrite=0, if_id_write=0, id_ex_bubble=1; stall_count+1; go to STALL.
  3. halt_detect=1: PCWrite=0, if_id_write=0, id_ex_bubble=1; go to HALT.
  4. Otherwise: PCWrite=1, if_id_write=1, all other outputs 0.
- STALL:
  - Lasts exactly one cycle.
  - Outputs as in RUN case 4, except a branch_taken arriving in this cycle is handled as RUN case 1 (branch wins).
  - Next state is RUN, or FLUSH per RUN case 1.
  - A hazard still asserted re-enters STALL via RUN on the following cycle; back-to-back stalls are legal.
- FLUSH:
  - PCWrite=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; flush_count+1.
  - Counter 0 → RUN; else decrement.
  - load_use_hazard and halt_detect are ignored (they refer to squashed instructions).
  - A new branch_taken in FLUSH restarts the redirect: Branchreg=branch_reg, counter reloads FLUSH_DEPTH-2.
- HALT:
  - PCWrite=0, if_id_write=0, id_ex_bubble=1.
  - resume=1 → RUN next edge.
  - branch_taken in HALT is ignored.
- Branchreg is 0 in every cycle that is not a redirect cycle.
- Counters saturate at all-ones and never wrap.
- Simultaneous branch_taken, load_use_hazard and halt_detect in RUN: the branch wins; the hazard and halt are dropped because the instructions are squashed.

Test Plan:
- Boot: reset high 3 cycles, then low → PCWrite=0 for exactly 4 cycles, PCWrite=1 on cycle 5, state_out goes 0→1.
- Load-use: in RUN, load_use_hazard=1 for 1 cycle → one cycle PCWrite=0, if_id_write=0, id_ex_bubble=1; state 1→2→1; stall_count=1.
- Register branch: branch_taken=1, branch_reg=1 in RUN → same cycle PCWrite=1, Branchreg=1, if_id_flush=1; next cycle state=3 with if_id_flush=1, id_ex_bubble=1; then RUN; flush_count=2.
- Collision: branch_taken, load_use_hazard and halt_detect all 1 in RUN → redirect only; stall_count unchanged, no HALT entry.
- Halt/resume: halt_detect=1 → state 4, PCWrite=0 held 10 cycles despite branch_taken pulses; resume pulse → RUN with PCWrite=1 on the next cycle.
- Async reset in FLUSH: assert reset mid-cycle → outputs drop to 0 before the next edge; state_out=0; both counters=0.
